// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shifts and shift-add multiply.
// Result and compare flags are held in registers until the consumer takes them.
module alu_mc #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry,
  output logic          eq,
  output logic          lt,
  output logic          lts
);

  localparam int unsigned SW = $clog2(DW);
  localparam int unsigned CW = SW + 1;
  localparam int unsigned AW = 2 * DW;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] work_q, work_d;
  logic [AW-1:0] mcand_q, mcand_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] result_d;
  logic          zero_d, carry_d, eq_d, lt_d, lts_d;
  logic          in_ready_d, out_valid_d;

  logic [2:0]    s_op;
  logic [DW-1:0] s_work, st_work;
  logic [AW-1:0] s_mcand, st_mcand, s_acc, st_acc;
  logic [CW-1:0] s_cnt, cnt_dec;
  logic          st_bit;
  logic [DW:0]   sum, diff;
  logic [DW-1:0] direct_res, fin_res;
  logic          direct_carry, fin_carry;
  logic          step_en;

  // One iteration step. In IDLE it acts on the incoming operands so the accept
  // cycle already performs the first iteration; in BUSY it acts on the registers.
  always_comb begin
    s_op    = op_q;
    s_work  = work_q;
    s_mcand = mcand_q;
    s_acc   = acc_q;
    s_cnt   = cnt_q;
    if (state_q == IDLE) begin
      s_op    = op;
      s_work  = (op == OP_MUL) ? b : a;
      s_mcand = {DW'(0), a};
      s_acc   = '0;
      case (op)
        OP_SLL, OP_SRL: s_cnt = CW'(b[SW-1:0]);
        OP_MUL:         s_cnt = CW'(DW);
        default:        s_cnt = '0;
      endcase
    end

    st_work  = s_work;
    st_mcand = s_mcand;
    st_acc   = s_acc;
    st_bit   = 1'b0;
    case (s_op)
      OP_SLL: begin
        st_work = {s_work[DW-2:0], 1'b0};
        st_bit  = s_work[DW-1];
      end
      OP_SRL: begin
        st_work = {1'b0, s_work[DW-1:1]};
        st_bit  = s_work[0];
      end
      OP_MUL: begin
        st_acc   = s_acc + (s_work[0] ? s_mcand : AW'(0));
        st_mcand = {s_mcand[AW-2:0], 1'b0};
        st_work  = {1'b0, s_work[DW-1:1]};
      end
      default: ;
    endcase
    cnt_dec = s_cnt - CW'(1);

    if (s_op == OP_MUL) begin
      fin_res   = st_acc[DW-1:0];
      fin_carry = |st_acc[AW-1:DW];
    end else begin
      fin_res   = st_work;
      fin_carry = st_bit;
    end
  end

  // Single-cycle results (also covers shifts by zero).
  always_comb begin
    sum          = {1'b0, a} + {1'b0, b};
    diff         = {1'b0, a} - {1'b0, b};
    direct_res   = a;
    direct_carry = 1'b0;
    case (op)
      OP_ADD: begin direct_res = sum[DW-1:0];  direct_carry = sum[DW];  end
      OP_SUB: begin direct_res = diff[DW-1:0]; direct_carry = diff[DW]; end
      OP_AND: direct_res = a & b;
      OP_OR:  direct_res = a | b;
      OP_XOR: direct_res = a ^ b;
      default: ;
    endcase
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result;
    zero_d   = zero;
    carry_d  = carry;
    eq_d     = eq;
    lt_d     = lt;
    lts_d    = lts;
    step_en  = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d  = op;
            eq_d  = (a == b);
            lt_d  = (a < b);
            lts_d = ($signed(a) < $signed(b));
            if (s_cnt == '0) begin
              result_d = direct_res;
              carry_d  = direct_carry;
              zero_d   = (direct_res == '0);
              state_d  = DONE;
            end else begin
              step_en = 1'b1;
            end
          end
        end
        BUSY: step_en = 1'b1;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (step_en) begin
        work_d  = st_work;
        mcand_d = st_mcand;
        acc_d   = st_acc;
        cnt_d   = cnt_dec;
        if (cnt_dec == '0) begin
          result_d = fin_res;
          carry_d  = fin_carry;
          zero_d   = (fin_res == '0);
          state_d  = DONE;
        end else begin
          state_d = BUSY;
        end
      end
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      work_q    <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      lts       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      work_q    <= work_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      result    <= result_d;
      zero      <= zero_d;
      carry     <= carry_d;
      eq        <= eq_d;
      lt        <= lt_d;
      lts       <= lts_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model.
module tb_alu_mc;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] result;
  logic          zero, carry, eq, lt, lts;

  int errors = 0;
  int checks = 0;

  alu_mc #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carry(carry), .eq(eq), .lt(lt), .lts(lts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int carry;
    int zero;
    int eq;
    int lt;
    int lts;
    int lat;
  } exp_t;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference behaviour from plain arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t e;
    int xi, yi, n, p, mask;
    xi = int'(x);
    yi = int'(y);
    mask = (1 << DW) - 1;
    n = yi % DW;
    e.carry = 0;
    e.lat = 1;
    case (o)
      3'd0: begin e.res = (xi + yi) & mask; e.carry = int'((xi + yi) > mask); end
      3'd1: e.res = xi & yi;
      3'd2: e.res = xi | yi;
      3'd3: e.res = xi ^ yi;
      3'd4: begin e.res = (xi - yi) & mask; e.carry = int'(xi < yi); end
      3'd5: begin
        e.res = (xi << n) & mask;
        e.carry = (n > 0) ? ((xi >> (DW - n)) & 1) : 0;
        e.lat = (n > 0) ? n : 1;
      end
      3'd6: begin
        e.res = xi >> n;
        e.carry = (n > 0) ? ((xi >> (n - 1)) & 1) : 0;
        e.lat = (n > 0) ? n : 1;
      end
      default: begin
        p = xi * yi;
        e.res = p & mask;
        e.carry = int'((p >> DW) != 0);
        e.lat = DW;
      end
    endcase
    e.zero = int'(e.res == 0);
    e.eq   = int'(xi == yi);
    e.lt   = int'(xi < yi);
    e.lts  = int'($signed(x) < $signed(y));
    return e;
  endfunction

  // Model state: pending op countdown, done flag, whether held values are defined.
  exp_t m_exp;
  int   m_wait = -1;
  bit   m_done = 1'b0;
  bit   m_hold = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_result", int'(result), 0);
      m_exp.res = 0; m_exp.carry = 0; m_exp.zero = 0;
      m_exp.eq = 0; m_exp.lt = 0; m_exp.lts = 0; m_exp.lat = 0;
      m_done = 1'b0;
      m_wait = -1;
      m_hold = 1'b1;
    end else begin
      chk("out_valid", int'(out_valid), int'(m_done));
      chk("in_ready", int'(in_ready), int'(!m_done && m_wait < 0));
      if (m_done || (m_hold && m_wait < 0)) begin
        chk("result", int'(result), m_exp.res);
        chk("carry", int'(carry), m_exp.carry);
        chk("zero", int'(zero), m_exp.zero);
        chk("eq", int'(eq), m_exp.eq);
        chk("lt", int'(lt), m_exp.lt);
        chk("lts", int'(lts), m_exp.lts);
      end
      if (flush) begin
        m_done = 1'b0;
        m_wait = -1;
      end else if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_done = 1'b1; m_wait = -1; m_hold = 1'b1; end
      end else if (in_valid) begin
        m_exp  = model(op, a, b);
        m_hold = 1'b0;
        m_wait = m_exp.lat - 1;
        if (m_wait == 0) begin m_done = 1'b1; m_wait = -1; m_hold = 1'b1; end
      end
    end
  end

  // Offer one op (called just after a rising edge); scramble inputs after accept.
  task automatic issue(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("issue_in_ready", int'(in_ready), 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = DW'($urandom); b = DW'($urandom);
  endtask

  task automatic run(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y, output int lat);
    issue(o, x, y);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [2:0]    v_op [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd0, 3'd7};
  logic [DW-1:0] v_a  [10] = '{8'hCC, 8'hCC, 8'hCC, 8'h03, 8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'h7F, 8'h00};
  logic [DW-1:0] v_b  [10] = '{8'hAA, 8'hAA, 8'hAA, 8'h80, 8'h07, 8'h07, 8'h0B, 8'hFF, 8'h80, 8'h37};

  initial begin
    int lat;
    int seen;
    exp_t e;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_result", int'(result), 0);

    run(3'd0, 8'hF0, 8'h20, lat);
    chk("add_lat", lat, 1);
    chk("add_result", int'(result), 'h10);
    chk("add_carry", int'(carry), 1);
    chk("add_flags", int'({zero, eq, lt, lts}), 'b0001);
    take();

    run(3'd4, 8'h05, 8'h05, lat);
    chk("sub_result", int'(result), 0);
    chk("sub_flags", int'({zero, carry, eq}), 'b101);
    take();

    run(3'd5, 8'h81, 8'h03, lat);
    chk("sll3_lat", lat, 3);
    chk("sll3_result", int'(result), 'h08);
    chk("sll3_carry", int'(carry), 0);
    take();

    run(3'd6, 8'h81, 8'h01, lat);
    chk("srl1_lat", lat, 1);
    chk("srl1_result", int'({carry, result}), 'h140);
    take();

    run(3'd5, 8'h81, 8'h00, lat);
    chk("sll0_lat", lat, 1);
    chk("sll0_result", int'(result), 'h81);
    take();

    run(3'd7, 8'h10, 8'h11, lat);
    chk("mul_lat", lat, 8);
    chk("mul_result", int'({carry, result}), 'h110);
    take();

    run(3'd7, 8'h0F, 8'h03, lat);
    chk("mul2_result", int'({carry, result}), 'h02D);
    take();

    e = model(3'd5, 8'h81, 8'h03);
    chk("model_sll_pin", e.res | (e.carry << 8) | (e.lat << 12), 'h3008);

    for (int i = 0; i < 10; i++) begin
      e = model(v_op[i], v_a[i], v_b[i]);
      run(v_op[i], v_a[i], v_b[i], lat);
      chk("vec_lat", lat, e.lat);
      take();
    end

    // Backpressure: held result, no accept while DONE.
    run(3'd0, 8'h7F, 8'h01, lat);
    op = 3'd3; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_result", int'(result), 'h80);
    end
    in_valid = 1'b0;
    take();

    // Flush during multiply.
    issue(3'd7, 8'h23, 8'h45);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_busy_no_valid", seen, 0);

    // Flush overrides an output handshake in DONE.
    run(3'd0, 8'h01, 8'h01, lat);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b0;
    chk("flush_done_valid", int'(out_valid), 0);
    chk("flush_done_held", int'(result), 'h02);

    // Asynchronous reset while a multiply is in flight.
    issue(3'd7, 8'h10, 8'h11);
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", int'(in_ready), 1);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_result", int'({result, zero, carry, eq, lt, lts}), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("post_rst_no_valid", seen, 0);
    run(3'd0, 8'h03, 8'h04, lat);
    chk("post_rst_add", int'(result) | (lat << 8), 'h107);
    take();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
